// File: rtl/shift_register_pkg.sv
`default_nettype none
// ============================================================================
// Module  : shift_register_pkg
// Purpose : Shared types and constants for the serial shift register block.
//           - DEPTH_DEFAULT     : default number of stages between x0 and x1
//           - DEPTH_MAX         : largest DEPTH accepted at elaboration
//           - RESET_VAL_DEFAULT : value every stage holds while in reset
//           - stage_t           : storage type of a single stage
// Revision: 1.0 - initial release
// ============================================================================
package shift_register_pkg;

    typedef logic stage_t;

    localparam int     DEPTH_DEFAULT     = 2;
    localparam int     DEPTH_MAX         = 32;
    localparam stage_t RESET_VAL_DEFAULT = 1'b0;

endpackage : shift_register_pkg
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
// Module  : shift_stage
// Purpose : One stage of the serial shift register: a single D flop with an
//           asynchronous active-low clear to RESET_VAL.
// Ports   : clk_i   - rising-edge clock
//           reset_i - asynchronous active-low clear
//           d       - stage input
//           q       - stage output (registered)
// Revision: 1.0 - initial release
// ============================================================================
module shift_stage
    import shift_register_pkg::*;
#(
    parameter stage_t RESET_VAL = RESET_VAL_DEFAULT
) (
    input  logic   clk_i,
    input  logic   reset_i,
    input  stage_t d,
    output stage_t q
);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            q <= RESET_VAL;
        end else begin
            q <= d;
        end
    end

endmodule : shift_stage
`default_nettype wire

// File: rtl/shift_register_blocking_nonblocking.sv
`default_nettype none
// ============================================================================
// Module  : shift_register_blocking_nonblocking
// Purpose : Single-bit serial shift register. x0 is sampled on every rising
//           clk_i edge and appears on x1 after DEPTH edges. Demonstrates the
//           difference between a stage-per-flop chain and a chain updated in
//           blocking order.
// Macro   : SHIFT_REG_BLOCKING_EN - when defined, stages are updated in
//           blocking order within one edge, so the chain collapses and the
//           latency becomes 1 cycle regardless of DEPTH.
// Ports   : clk_i   - rising-edge clock
//           reset_i - asynchronous active-low reset, clears all stages
//           x0      - serial data in
//           x1      - serial data out, straight from the last stage flop
// Revision: 1.0 - initial release
// ============================================================================
module shift_register_blocking_nonblocking
    import shift_register_pkg::*;
#(
    parameter int     DEPTH     = DEPTH_DEFAULT,
    parameter stage_t RESET_VAL = RESET_VAL_DEFAULT
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic x0,
    output logic x1
);

    // Reject unsupported depths at elaboration time.
    if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_depth_check
        $error("shift_register_blocking_nonblocking: DEPTH must be 1..32");
    end

    stage_t stage [DEPTH];

`ifdef SHIFT_REG_BLOCKING_EN
    // Blocking-order update: stage[0] takes x0 first and each later stage
    // copies its already-updated predecessor, so every stage ends up with x0.
    stage_t stage_nxt [DEPTH];

    always_comb begin
        stage_t carry;
        carry = x0;
        for (int k = 0; k < DEPTH; k++) begin
            stage_nxt[k] = carry;
            carry        = stage_nxt[k];
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= RESET_VAL;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= stage_nxt[k];
            end
        end
    end
`else
    // Non-blocking chain: each stage samples its predecessor's old value,
    // giving one cycle of delay per stage.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            shift_stage #(
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .d       (x0),
                .q       (stage[k])
            );
        end else begin : g_next
            shift_stage #(
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .d       (stage[k-1]),
                .q       (stage[k])
            );
        end
    end
`endif

    assign x1 = stage[DEPTH-1];

endmodule : shift_register_blocking_nonblocking
`default_nettype wire

// File: tb/tb_shift_register_blocking_nonblocking.sv
`default_nettype none
// ============================================================================
// Module  : tb_shift_register_blocking_nonblocking
// Purpose : Self-checking bench for shift_register_blocking_nonblocking.
//           Two instances (DEPTH=2 and DEPTH=4) share clock, reset and x0.
//           A reference model keeps the history of sampled x0 bits in a
//           queue; x1 is expected to equal the bit sampled LAT edges ago, or
//           the reset value when fewer than LAT bits were captured since
//           reset. With SHIFT_REG_BLOCKING_EN defined, LAT is 1 for both.
// Revision: 1.0 - initial release
// ============================================================================
module tb_shift_register_blocking_nonblocking;

`ifdef SHIFT_REG_BLOCKING_EN
    localparam int LAT_A = 1;
    localparam int LAT_B = 1;
`else
    localparam int LAT_A = 2;
    localparam int LAT_B = 4;
`endif

    logic clk_i   = 1'b0;
    logic reset_i = 1'b0;
    logic x0      = 1'b0;
    logic x1_a;
    logic x1_b;

    int passed = 0;
    int total  = 0;

    // Sampled history, newest bit at index 0; cleared by reset.
    bit hist [$];

    always #5 clk_i = ~clk_i;

    shift_register_blocking_nonblocking #(
        .DEPTH     (2),
        .RESET_VAL (1'b0)
    ) u_dut_a (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .x0      (x0),
        .x1      (x1_a)
    );

    shift_register_blocking_nonblocking #(
        .DEPTH     (4),
        .RESET_VAL (1'b0)
    ) u_dut_b (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .x0      (x0),
        .x1      (x1_b)
    );

    function automatic logic model_out(input int lat);
        if (hist.size() >= lat) return hist[lat-1];
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_both(input string tag);
        check({tag, "/d2"}, x1_a, model_out(LAT_A));
        check({tag, "/d4"}, x1_b, model_out(LAT_B));
    endtask

    // Drive x0 and reset on the falling edge, let one rising edge happen,
    // update the model, then compare shortly after the edge.
    task automatic cyc(input string tag, input logic x, input logic rst_n);
        @(negedge clk_i);
        x0      = x;
        reset_i = rst_n;
        if (!rst_n) hist.delete();
        @(posedge clk_i);
        if (reset_i) begin
            hist.push_front(x0);
            while (hist.size() > 8) void'(hist.pop_back());
        end
        #2;
        check_both(tag);
    endtask

    // Drop reset between edges and verify the outputs clear without a clock.
    task automatic async_reset(input string tag);
        @(posedge clk_i);
        #2;
        reset_i = 1'b0;
        hist.delete();
        #1;
        check_both(tag);
    endtask

    initial begin
        // Reset state before any edge.
        #1;
        check_both("reset_initial");

        // Reset hold with x0 high.
        for (int i = 0; i < 3; i++) cyc("reset_hold", 1'b1, 1'b0);

        // Basic latency: release and hold x0=1.
        for (int i = 0; i < 10; i++) cyc("latency", 1'b1, 1'b1);

        // Pattern propagation.
        cyc("pattern", 1'b0, 1'b1);
        cyc("pattern", 1'b0, 1'b1);
        cyc("pattern", 1'b0, 1'b1);
        cyc("pattern", 1'b0, 1'b1);
        cyc("pattern", 1'b1, 1'b1);
        cyc("pattern", 1'b0, 1'b1);
        cyc("pattern", 1'b1, 1'b1);
        cyc("pattern", 1'b1, 1'b1);
        cyc("pattern", 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc("pattern_tail", 1'b0, 1'b1);

        // Asynchronous reset while x1 is high, then refill.
        for (int i = 0; i < 5; i++) cyc("prefill", 1'b1, 1'b1);
        async_reset("async_reset");
        cyc("reset_low_edge", 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cyc("refill", 1'b1, 1'b1);

        // Single-cycle pulse, observed on both depths.
        for (int i = 0; i < 5; i++) cyc("pulse_pre", 1'b0, 1'b1);
        cyc("pulse", 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cyc("pulse_post", 1'b0, 1'b1);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                async_reset("rand_async_reset");
                cyc("rand_reset_edge", 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                cyc("rand", 1'($urandom_range(0, 1)), 1'b1);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_shift_register_blocking_nonblocking
`default_nettype wire
